// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: two-requester arbiter/sequencer for the RW port (port 0) of the 1024x32 OpenRAM macro
//
// Ports:
//   clk_i, rst_i                  clock (same as macro clk0), synchronous active-high reset
//   req_i, we_i                   per-requester request valid and write enable
//   wmask_i, addr_i, wdata_i      per-requester fields, slice k = [k*W +: W]
//   gnt_o                         request accepted this cycle
//   rvalid_o, rdata_o, rready_i   per-requester response channel (rdata 0 for writes)
//   sram_csb_o .. sram_din_o      drive for macro csb0/web0/wmask0/addr0/din0
//   sram_dout_i                   macro dout0
//
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins
// contention); otherwise round-robin between the two requesters.
module sram_port0_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [1:0]              we_i,
    input  logic [2*NUM_WMASKS-1:0] wmask_i,
    input  logic [2*ADDR_WIDTH-1:0] addr_i,
    input  logic [2*DATA_WIDTH-1:0] wdata_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              rvalid_o,
    output logic [2*DATA_WIDTH-1:0] rdata_o,
    input  logic [1:0]              rready_i,
    output logic                    sram_csb_o,
    output logic                    sram_web_o,
    output logic [NUM_WMASKS-1:0]   sram_wmask_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_din_o,
    input  logic [DATA_WIDTH-1:0]   sram_dout_i
);
    logic [1:0]                 elig;
    logic                       grant;
    logic                       sel;
    logic                       infl_v;
    logic                       infl_id;
    logic                       infl_we;
    logic [1:0]                 land;
    logic [1:0]                 rvalid_q;
    logic [1:0][DATA_WIDTH-1:0] rdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                       last_q;
`endif

    // A requester may issue when it has nothing in flight and its response slot is
    // empty or being drained this very cycle.
    assign elig[0] = req_i[0] & ~(infl_v & ~infl_id) & (~rvalid_q[0] | rready_i[0]);
    assign elig[1] = req_i[1] & ~(infl_v & infl_id) & (~rvalid_q[1] | rready_i[1]);
    assign grant   = |elig & ~rst_i;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign sel = ~elig[0];
`else
    assign sel = &elig ? ~last_q : elig[1];
`endif

    assign gnt_o        = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign sram_csb_o   = ~grant;
    assign sram_web_o   = grant ? ~we_i[sel] : 1'b1;
    assign sram_wmask_o = grant ? (sel ? wmask_i[2*NUM_WMASKS-1:NUM_WMASKS] : wmask_i[NUM_WMASKS-1:0]) : '0;
    assign sram_addr_o  = grant ? (sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0]) : '0;
    assign sram_din_o   = grant ? (sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0]) : '0;

    // The macro presents dout0 during the cycle after the grant; capture it at the end of that cycle.
    assign land     = {infl_v & infl_id, infl_v & ~infl_id};
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_v   <= 1'b0;
            infl_id  <= 1'b0;
            infl_we  <= 1'b0;
            rvalid_q <= '0;
            rdata_q  <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            infl_v  <= grant;
            infl_id <= sel;
            infl_we <= we_i[sel];
`ifndef SRAM_ARB_FIXED_PRIO_EN
            if (grant) last_q <= sel;
`endif
            for (int k = 0; k < 2; k++) begin
                rvalid_q[k] <= land[k] | (rvalid_q[k] & ~rready_i[k]);
                if (land[k]) rdata_q[k] <= infl_we ? '0 : sram_dout_i;
            end
        end
    end
endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: directed and randomized bench for sram_port0_arbiter against a transaction-level model
module tb_sram_port0_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, rready, gnt_o, rvalid_o;
    logic [7:0]  wmask;
    logic [19:0] addr;
    logic [63:0] wdata, rdata_o;
    logic        sram_csb_o, sram_web_o;
    logic [3:0]  sram_wmask_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_din_o, sram_dout;

    int checks = 0;
    int failures = 0;

    sram_port0_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .wmask_i(wmask),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .rready_i(rready), .sram_csb_o(sram_csb_o),
        .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o), .sram_addr_o(sram_addr_o),
        .sram_din_o(sram_din_o), .sram_dout_i(sram_dout)
    );

    always #5 clk = ~clk;

    // macro model: samples at posedge, writes or reads at the following negedge
    logic [31:0] mem [1024] = '{default: '0};
    logic        csb_r = 1'b1, web_r = 1'b1;
    logic [3:0]  wm_r = '0;
    logic [9:0]  a_r = '0;
    logic [31:0] din_r = '0;
    always @(posedge clk) begin
        csb_r <= sram_csb_o;
        web_r <= sram_web_o;
        wm_r  <= sram_wmask_o;
        a_r   <= sram_addr_o;
        din_r <= sram_din_o;
    end
    always @(negedge clk) begin
        if (!csb_r) begin
            if (!web_r) begin
                for (int b = 0; b < 4; b++)
                    if (wm_r[b]) mem[a_r][b*8 +: 8] <= din_r[b*8 +: 8];
            end else begin
                sram_dout <= mem[a_r];
            end
        end
    end

    // transaction model: memory updated in grant order, one pending response per requester
    logic [31:0] ref_mem [1024] = '{default: '0};
    int          cyc = 0;
    int          last_g [2];
    int          rdy [2];
    bit          have [2];
    logic [31:0] data [2];
    bit          last_w;
    logic [1:0]  seen_gnt, seen_rv;
    logic        seen_csb;
    logic [31:0] seen_rd [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_g[k] = -10;
            have[k] = 0;
        end
        last_w = 1;
    endtask

    task automatic set_req(input int k, input bit w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        req[k] = 1'b1;
        we[k] = w;
        addr[k*10 +: 10] = a;
        wdata[k*32 +: 32] = d;
        wmask[k*4 +: 4] = m;
    endtask

    // one clock cycle: entered and left at negedge with inputs already applied
    task automatic step();
        logic [1:0] el, erv, eg;
        logic       w;
        int         wi;
        logic [9:0] a;
        #1;
        for (int k = 0; k < 2; k++) begin
            erv[k] = have[k] && cyc >= rdy[k];
            el[k] = !rst && req[k] && (cyc - last_g[k] >= 2) && (!erv[k] || rready[k]);
        end
`ifdef SRAM_ARB_FIXED_PRIO_EN
        w = !el[0];
`else
        if (el == 2'b11) w = !last_w;
        else w = el[1];
`endif
        wi = int'(w);
        eg = (el == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
        seen_gnt = gnt_o;
        seen_rv = rvalid_o;
        seen_csb = sram_csb_o;
        for (int k = 0; k < 2; k++) seen_rd[k] = rdata_o[k*32 +: 32];
        check("gnt", gnt_o, eg);
        check("csb", sram_csb_o, eg == 2'b00);
        check("web", sram_web_o, eg == 2'b00 ? 1'b1 : !we[wi]);
        check("wmask", sram_wmask_o, eg == 2'b00 ? 4'h0 : wmask[wi*4 +: 4]);
        check("addr", sram_addr_o, eg == 2'b00 ? 10'h0 : addr[wi*10 +: 10]);
        check("din", sram_din_o, eg == 2'b00 ? 32'h0 : wdata[wi*32 +: 32]);
        check("rvalid", rvalid_o, erv);
        for (int k = 0; k < 2; k++)
            if (erv[k]) check("rdata", rdata_o[k*32 +: 32], data[k]);
        for (int k = 0; k < 2; k++)
            if (erv[k] && rready[k]) have[k] = 0;
        if (eg != 2'b00) begin
            last_g[wi] = cyc;
            last_w = w;
            have[wi] = 1;
            rdy[wi] = cyc + 2;
            a = addr[wi*10 +: 10];
            if (we[wi]) begin
                data[wi] = '0;
                for (int b = 0; b < 4; b++)
                    if (wmask[wi*4 + b]) ref_mem[a][b*8 +: 8] = wdata[wi*32 + b*8 +: 8];
            end else begin
                data[wi] = ref_mem[a];
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input int k, input bit w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        int n = 0;
        set_req(k, w, a, d, m);
        do begin
            step();
            n++;
        end while (!seen_gnt[k] && n < 20);
        check("issue_gnt", seen_gnt[k], 1'b1);
        req[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, output logic [31:0] d, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!seen_rv[k] && lat < 20);
        d = seen_rd[k];
    endtask

    initial begin
        logic [31:0] rd;
        int lat, n1;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat, n1;
        rst = 1'b1;
        req = '0;
        we = '0;
        wmask = '0;
        addr = '0;
        wdata = '0;
        rready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_rvalid", rvalid_o, 2'b00);
        check("rst_rdata", rdata_o, 64'h0);
        check("rst_csb", sram_csb_o, 1'b1);
        check("rst_web", sram_web_o, 1'b1);
        check("rst_addr", sram_addr_o, 10'h0);
        step();

        // single read after a preload from requester 1
        issue(1, 1, 10'h005, 32'hDEADBEEF, 4'hF);
        idle(3);
        issue(0, 0, 10'h005, 32'h0, 4'h0);
        wait_resp(0, rd, lat);
        check("single_rd_data", rd, 32'hDEADBEEF);
        check("single_rd_lat", lat, 2);

        // byte-masked write then read
        issue(1, 1, 10'h3FF, 32'h11223344, 4'hF);
        wait_resp(1, rd, lat);
        check("wr1_resp", rd, 32'h0);
        issue(1, 1, 10'h3FF, 32'hAABBCCDD, 4'h5);
        wait_resp(1, rd, lat);
        check("wr2_resp", rd, 32'h0);
        issue(1, 0, 10'h3FF, 32'h0, 4'h0);
        wait_resp(1, rd, lat);
        check("masked_rd", rd, 32'h11BB33DD);
        issue(0, 1, 10'h3FF, 32'hFFFFFFFF, 4'h0);
        wait_resp(0, rd, lat);
        issue(0, 0, 10'h3FF, 32'h0, 4'h0);
        wait_resp(0, rd, lat);
        check("zero_mask_rd", rd, 32'h11BB33DD);
        idle(2);

        // backpressure on requester 0 while requester 1 keeps issuing
        rready = 2'b10;
        issue(0, 0, 10'h005, 32'h0, 4'h0);
        set_req(0, 0, 10'h006, 32'h0, 4'h0);
        set_req(1, 0, 10'h3FF, 32'h0, 4'h0);
        n1 = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_no_gnt0", seen_gnt[0], 1'b0);
            n1 += int'(seen_gnt[1]);
        end
        check("bp_gnt1_count", n1, 3);
        rready = 2'b11;
        step();
        check("bp_regnt0", seen_gnt, 2'b01);
        req = '0;
        idle(4);

        // read-after-write across requesters in consecutive grants
        set_req(1, 1, 10'h0A5, 32'hCAFEF00D, 4'hF);
        step();
        check("raw_wr_gnt", seen_gnt, 2'b10);
        req = '0;
        set_req(0, 0, 10'h0A5, 32'h0, 4'h0);
        step();
        check("raw_rd_gnt", seen_gnt, 2'b01);
        req = '0;
        wait_resp(0, rd, lat);
        check("raw_rd_data", rd, 32'hCAFEF00D);
        check("raw_rd_lat", lat, 2);
        idle(3);

        // reset in the cycle after a read grant
        issue(0, 0, 10'h0A5, 32'h0, 4'h0);
        rst = 1'b1;
        set_req(1, 0, 10'h001, 32'h0, 4'h0);
        step();
        check("rst_no_gnt", seen_gnt, 2'b00);
        check("rst_no_rv", seen_rv, 2'b00);
        rst = 1'b0;
        req = '0;
        step();
        check("rst_idle_csb", seen_csb, 1'b1);
        check("rst_no_rv2", seen_rv, 2'b00);

        // contention: both read continuously, first grant goes to requester 0
        set_req(0, 0, 10'($urandom_range(0, 1023)), 32'h0, 4'h0);
        set_req(1, 0, 10'($urandom_range(0, 1023)), 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("cont_gnt", seen_gnt, (i % 2) ? 2'b10 : 2'b01);
            for (int k = 0; k < 2; k++)
                if (seen_gnt[k]) set_req(k, 0, 10'($urandom_range(0, 1023)), 32'h0, 4'h0);
        end
        req = '0;
        idle(4);

        // randomized traffic with occasional resets; small address range for RAW hits
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 2; k++)
                if (!req[k] || seen_gnt[k]) begin
                    req[k] = 1'b0;
                    if ($urandom_range(0, 3) != 0)
                        set_req(k, 1'($urandom), 10'($urandom_range(0, 15)), 32'($urandom), 4'($urandom));
                end
            rready = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        rready = 2'b11;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
